// File: rtl/alu_pkg.sv
// Shared types for the ALU result checker: opcode encoding, checker FSM states
// and default sizing.
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 8;
  localparam int ALU_DEFAULT_CNT_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // A new run may be armed from any state except an active run.
  function automatic logic start_allowed(input chk_state_e s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: produces the expected WIDTH-bit result for a/b/op.
// Arithmetic and shifts wrap silently; there is no carry output.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] exp_out
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    exp_out = '0;
    unique case (alu_op_e'(op))
      OP_ADD:  exp_out = a + b;
      OP_SUB:  exp_out = a - b;
      OP_AND:  exp_out = a & b;
      OP_OR:   exp_out = a | b;
      OP_XOR:  exp_out = a ^ b;
      OP_NOT:  exp_out = ~a;
      OP_SHL:  exp_out = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  exp_out = {1'b0, a[WIDTH-1:1]};
      default: exp_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Checks a stream of ALU transactions against alu_ref_model for a run of num_txn
// transactions. Define ALU_CHK_CAPTURE_EN to keep the first failing transaction.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH,
  parameter int CNT_W = ALU_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_got,
  output logic [WIDTH-1:0] fail_exp
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e       r_state;
  chk_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_num_txn;
  logic [CNT_W-1:0] r_txn_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] w_exp;
  logic             w_arm;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_last;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a       (a),
    .b       (b),
    .op      (op),
    .exp_out (w_exp)
  );

  assign w_arm      = start && start_allowed(r_state);
  assign w_accept   = in_valid && (r_state == ST_RUN);
  assign w_mismatch = w_accept && (dut_out != w_exp);
  assign w_last     = (r_txn_cnt + CNT_ONE) == r_num_txn;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and ordering between always_ff blocks is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = (num_txn != '0) ? ST_RUN : ST_DONE;
      ST_RUN:           if (w_accept && w_last) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every register, including the captured run length, is reset so a
  // run interrupted by rst_n leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_txn <= '0;
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_arm) begin
      r_num_txn <= num_txn;
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_txn_cnt <= r_txn_cnt + CNT_ONE;
      if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

`ifdef ALU_CHK_CAPTURE_EN
  logic             r_fail_vld;
  logic [2:0]       r_fail_op;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH-1:0] r_fail_got;
  logic [WIDTH-1:0] r_fail_exp;

  // Only the first mismatch of a run is kept; r_fail_vld blocks later overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_vld <= 1'b0;
      r_fail_op  <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_got <= '0;
      r_fail_exp <= '0;
    end else if (w_arm) begin
      r_fail_vld <= 1'b0;
      r_fail_op  <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_got <= '0;
      r_fail_exp <= '0;
    end else if (w_mismatch && !r_fail_vld) begin
      r_fail_vld <= 1'b1;
      r_fail_op  <= op;
      r_fail_a   <= a;
      r_fail_b   <= b;
      r_fail_got <= dut_out;
      r_fail_exp <= w_exp;
    end
  end

  assign fail_op  = r_fail_op;
  assign fail_a   = r_fail_a;
  assign fail_b   = r_fail_b;
  assign fail_got = r_fail_got;
  assign fail_exp = r_fail_exp;
`else
  assign fail_op  = '0;
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_got = '0;
  assign fail_exp = '0;
`endif

  assign in_ready = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  // err_cnt saturates rather than wraps, so zero here really means no errors.
  assign pass     = (r_state == ST_DONE) && (r_err_cnt == '0);
  assign txn_cnt  = r_txn_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: table-driven runs with a counter
// scoreboard plus hand-written reset, zero-length and start-in-run sequences.
module tb_alu_result_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] got;
    logic [7:0] exp;
    bit         bad;
  } vec_t;

  typedef struct {
    int txn;
    int err;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_txn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] txn_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       fail_op;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [WIDTH-1:0] fail_got;
  logic [WIDTH-1:0] fail_exp;

  alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_txn  (num_txn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .txn_cnt  (txn_cnt),
    .err_cnt  (err_cnt),
    .fail_op  (fail_op),
    .fail_a   (fail_a),
    .fail_b   (fail_b),
    .fail_got (fail_got),
    .fail_exp (fail_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_txn    = 0;
  int   m_err    = 0;
  sb_t  sb_q[$];
  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic pulse_start(input int n);
    start   = 1'b1;
    num_txn = CNT_W'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    m_txn   = 0;
    m_err   = 0;
    sb_q.delete();
  endtask

  // Drive one transaction; the expected counters are queued as it is driven
  // and compared once the acceptance edge has passed.
  task automatic send(input vec_t v);
    sb_t e;
    a        = v.a;
    b        = v.b;
    op       = v.op;
    dut_out  = v.got;
    in_valid = 1'b1;
    m_txn++;
    if (v.bad) m_err++;
    sb_q.push_back('{txn: m_txn, err: m_err});
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb_q.pop_front();
    check("txn_cnt", 32'(txn_cnt), 32'(e.txn));
    check("err_cnt", 32'(err_cnt), 32'(e.err));
  endtask

  task automatic run_vecs(input string name, input int first, input int n);
    pulse_start(n);
    check({name, "_busy_start"}, 32'(busy), 32'd1);
    check({name, "_ready_start"}, 32'(in_ready), 32'd1);
    check({name, "_done_start"}, 32'(done), 32'd0);
    for (int i = 0; i < n; i++) send(tbl[first + i]);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_pass"}, 32'(pass), (m_err == 0) ? 32'd1 : 32'd0);
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_ready_end"}, 32'(in_ready), 32'd0);
  endtask

  task automatic pulse_idle_valid();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_pass"}, 32'(pass), 32'd0);
    check({name, "_txn"}, 32'(txn_cnt), 32'd0);
    check({name, "_err"}, 32'(err_cnt), 32'd0);
    check({name, "_fail_op"}, 32'(fail_op), 32'd0);
    check({name, "_fail_a"}, 32'(fail_a), 32'd0);
    check({name, "_fail_got"}, 32'(fail_got), 32'd0);
    check({name, "_fail_exp"}, 32'(fail_exp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // A=50, B=10 across all opcodes, correct results
    tbl[0]  = '{8'd50, 8'd10, 3'd0, 8'd60,  8'd60,  1'b0};
    tbl[1]  = '{8'd50, 8'd10, 3'd1, 8'd40,  8'd40,  1'b0};
    tbl[2]  = '{8'd50, 8'd10, 3'd2, 8'd2,   8'd2,   1'b0};
    tbl[3]  = '{8'd50, 8'd10, 3'd3, 8'd58,  8'd58,  1'b0};
    tbl[4]  = '{8'd50, 8'd10, 3'd4, 8'd56,  8'd56,  1'b0};
    tbl[5]  = '{8'd50, 8'd10, 3'd5, 8'd205, 8'd205, 1'b0};
    tbl[6]  = '{8'd50, 8'd10, 3'd6, 8'd100, 8'd100, 1'b0};
    tbl[7]  = '{8'd50, 8'd10, 3'd7, 8'd25,  8'd25,  1'b0};
    // wrap-around boundaries
    tbl[8]  = '{8'd10,  8'd50,  3'd1, 8'd216, 8'd216, 1'b0};
    tbl[9]  = '{8'd200, 8'd100, 3'd0, 8'd44,  8'd44,  1'b0};
    tbl[10] = '{8'd255, 8'd1,   3'd0, 8'd0,   8'd0,   1'b0};
    tbl[11] = '{8'd0,   8'd1,   3'd1, 8'd255, 8'd255, 1'b0};
    tbl[12] = '{8'd128, 8'd0,   3'd6, 8'd0,   8'd0,   1'b0};
    tbl[13] = '{8'd129, 8'd0,   3'd7, 8'd64,  8'd64,  1'b0};
    // two wrong results: 3rd (AND, got 3) and 6th (NOT, got 0)
    tbl[14] = '{8'd50, 8'd10, 3'd0, 8'd60,  8'd60,  1'b0};
    tbl[15] = '{8'd50, 8'd10, 3'd1, 8'd40,  8'd40,  1'b0};
    tbl[16] = '{8'd50, 8'd10, 3'd2, 8'd3,   8'd2,   1'b1};
    tbl[17] = '{8'd50, 8'd10, 3'd3, 8'd58,  8'd58,  1'b0};
    tbl[18] = '{8'd50, 8'd10, 3'd4, 8'd56,  8'd56,  1'b0};
    tbl[19] = '{8'd50, 8'd10, 3'd5, 8'd0,   8'd205, 1'b1};
    tbl[20] = '{8'd50, 8'd10, 3'd6, 8'd100, 8'd100, 1'b0};
    tbl[21] = '{8'd50, 8'd10, 3'd7, 8'd25,  8'd25,  1'b0};

    rst_n = 1'b0; start = 1'b0; num_txn = '0; in_valid = 1'b0;
    a = '0; b = '0; op = '0; dut_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    pulse_idle_valid();
    check("idle_valid_txn", 32'(txn_cnt), 32'd0);
    check("idle_valid_busy", 32'(busy), 32'd0);

    run_vecs("basic", 0, 8);
    check("basic_err", 32'(err_cnt), 32'd0);
    pulse_idle_valid();
    check("done_valid_txn", 32'(txn_cnt), 32'd8);
    check("done_hold", 32'(done), 32'd1);

    run_vecs("wrap", 8, 6);
    check("wrap_txn", 32'(txn_cnt), 32'd6);

    run_vecs("errs", 14, 8);
    check("errs_err", 32'(err_cnt), 32'd2);
    check("errs_pass", 32'(pass), 32'd0);
`ifdef ALU_CHK_CAPTURE_EN
    check("errs_fail_op", 32'(fail_op), 32'd2);
    check("errs_fail_a", 32'(fail_a), 32'd50);
    check("errs_fail_b", 32'(fail_b), 32'd10);
    check("errs_fail_got", 32'(fail_got), 32'(tbl[16].got));
    check("errs_fail_exp", 32'(fail_exp), 32'(tbl[16].exp));
`else
    check("errs_fail_op", 32'(fail_op), 32'd0);
    check("errs_fail_a", 32'(fail_a), 32'd0);
    check("errs_fail_b", 32'(fail_b), 32'd0);
    check("errs_fail_got", 32'(fail_got), 32'd0);
    check("errs_fail_exp", 32'(fail_exp), 32'd0);
`endif

    // zero-length run started from DONE clears the previous result
    pulse_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_pass", 32'(pass), 32'd1);
    check("zero_txn", 32'(txn_cnt), 32'd0);
    check("zero_err", 32'(err_cnt), 32'd0);
    check("zero_fail_op", 32'(fail_op), 32'd0);
    check("zero_fail_got", 32'(fail_got), 32'd0);
    pulse_idle_valid();
    check("zero_valid_txn", 32'(txn_cnt), 32'd0);
    check("zero_valid_busy", 32'(busy), 32'd0);

    // start during RUN must not restart or resize the run
    pulse_start(2);
    send(tbl[0]);
    start = 1'b1; num_txn = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    check("inrun_start_txn", 32'(txn_cnt), 32'd1);
    check("inrun_start_busy", 32'(busy), 32'd1);
    send(tbl[1]);
    check("inrun_done", 32'(done), 32'd1);
    check("inrun_pass", 32'(pass), 32'd1);

    // asynchronous reset mid-run, with a captured mismatch in flight
    pulse_start(8);
    for (int i = 0; i < 4; i++) send(tbl[14 + i]);
    check("midrun_err", 32'(err_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vecs("after_reset", 0, 8);
    check("after_reset_err", 32'(err_cnt), 32'd0);
    check("after_reset_txn", 32'(txn_cnt), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
